// File: rtl/gpio_arbiter_pkg.sv
// gpio_arbiter_pkg: constants shared by the GPIO register-port arbiter.
//   - GPIO register select codes.
//   - Arbiter FSM state encoding.
//   - A small one-hot helper used for grant and response vectors.
package gpio_arbiter_pkg;

  localparam logic [2:0] GPIOWR_A  = 3'd0;
  localparam logic [2:0] GPIODIR_A = 3'd1;
  localparam logic [2:0] GPIOIN    = 3'd2;
  localparam logic [2:0] GPIOWR_B  = 3'd3;
  localparam logic [2:0] GPIODIR_B = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arbState_t;

  function automatic logic [1:0] oneHot2(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/gpio_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
// Ports:
//   req    [1:0] in  request per requester
//   last         in  requester served most recently
//   gnt    [1:0] out one-hot grant, all zero when nothing is requested
//   gnt_id       out index of the granted requester (0 when nothing requested)
module rr_arb2
  import gpio_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt_id = 1'b0;
    gnt    = 2'b00;
    // With both requesting the one not served last goes next; otherwise the
    // single requester wins regardless of history.
    if (req == 2'b11) begin
      gnt_id = ~last;
    end else begin
      gnt_id = req[1];
    end
    if (req != 2'b00) begin
      gnt = oneHot2(gnt_id);
    end
  end

endmodule

// File: rtl/gpio_arbiter.sv
// gpio_arbiter: shares the single GPIO register port between the CPU
// load/store unit (requester 0) and the pattern/DMA engine (requester 1).
// A valid/ready handshake in IDLE latches the winner's request, the GPIO
// port is driven for one ACCESS cycle, and a one-cycle response pulse with
// registered read data follows in RESP.
//
// Build option: GPIO_ARB_LOCK_EN adds the req_lock port. A requester that
// holds req_lock at its handshake keeps exclusive ownership until one of its
// own transactions is accepted with req_lock low.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_valid/req_ready    per-requester handshake (bit n = requester n)
//   req_sel0/1, req_we,
//   req_wdata0/1           per-requester register select, write enable, data
//   rsp_valid, rsp_rdata   response pulse to the owner, captured read data
//   gpio_regSel, gpio_we,
//   gpio_di, gpio_do       GPIO register port
//   req_lock               per-requester lock request (GPIO_ARB_LOCK_EN only)
//
// state  | meaning
// IDLE   | arbitrating, req_ready shows the winner
// ACCESS | GPIO port driven from the latched request, read data captured
// RESP   | rsp_valid pulsed to the owner
module gpio_arbiter
  import gpio_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [SEL_W-1:0]  req_sel0,
  input  logic [SEL_W-1:0]  req_sel1,
  input  logic [1:0]        req_we,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [SEL_W-1:0]  gpio_regSel,
  output logic              gpio_we,
  output logic [DATA_W-1:0] gpio_di,
  input  logic [DATA_W-1:0] gpio_do
`ifdef GPIO_ARB_LOCK_EN
  ,
  input  logic [1:0]        req_lock
`endif
);

  arbState_t         state;
  arbState_t         stateNext;
  logic              last;
  logic              owner;
  logic              weQ;
  logic [SEL_W-1:0]  selQ;
  logic [DATA_W-1:0] wdataQ;
  logic [1:0]        eligible;
  logic [1:0]        gnt;
  logic              gntId;
  logic              handshake;

`ifdef GPIO_ARB_LOCK_EN
  logic locked;
  logic lockOwner;
  logic lockQ;

  // While locked only the lock owner may compete; the other side stalls.
  assign eligible = locked ? (req_valid & oneHot2(lockOwner)) : req_valid;
`else
  assign eligible = req_valid;
`endif

  rr_arb2 uArb (
    .req    (eligible),
    .last   (last),
    .gnt    (gnt),
    .gnt_id (gntId)
  );

  // gnt is a subset of req_valid, so a non-zero grant in IDLE is a handshake.
  assign handshake = (state == IDLE) && (gnt != 2'b00);

  // The GPIO select/data lines only ever carry latched values, so they hold
  // steady outside ACCESS and never follow the requester inputs.
  assign gpio_regSel = selQ;
  assign gpio_di     = wdataQ;

  always_comb begin
    stateNext = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    gpio_we   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = gnt & {2{~reset}};
        if (handshake) begin
          stateNext = ACCESS;
        end
      end
      ACCESS: begin
        gpio_we   = weQ;
        stateNext = RESP;
      end
      RESP: begin
        rsp_valid = oneHot2(owner);
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      selQ      <= SEL_W'(GPIOWR_A);
      weQ       <= 1'b0;
      wdataQ    <= '0;
      rsp_rdata <= '0;
`ifdef GPIO_ARB_LOCK_EN
      locked    <= 1'b0;
      lockOwner <= 1'b0;
      lockQ     <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      if (handshake) begin
        owner  <= gntId;
        last   <= gntId;
        selQ   <= gntId ? req_sel1 : req_sel0;
        weQ    <= req_we[gntId];
        wdataQ <= gntId ? req_wdata1 : req_wdata0;
`ifdef GPIO_ARB_LOCK_EN
        lockQ  <= req_lock[gntId];
`endif
      end
      // Read data is captured for writes too; it reflects the register
      // contents before the write commits on the same edge.
      if (state == ACCESS) begin
        rsp_rdata <= gpio_do;
      end
`ifdef GPIO_ARB_LOCK_EN
      // The lock state is applied when the transaction finishes. No IDLE
      // cycle lies between handshake and RESP, so taking a lock here is
      // indistinguishable from taking it at the handshake, and releasing it
      // here lets the unlocking transaction complete before the other side
      // can win.
      if (state == RESP) begin
        locked    <= lockQ;
        lockOwner <= owner;
      end
`endif
    end
  end

endmodule
